pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, bubbles injected before halt acknowledge (range 1..7).
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_rs1_addr_d, i_rs2_addr_d  input  ADDR_WIDTH  source registers of the instruction in decode.
REQ-006 i_rs1_addr_e, i_rs2_addr_e, i_rd_addr_e  input  ADDR_WIDTH  source and destination registers of the instruction in execute.
REQ-007 i_resultsrc_e  input  2  result select in execute; 2'b01 marks a load.
REQ-008 i_pcsrc_e  input  1  taken branch or jump resolved in execute.
REQ-009 i_rd_addr_m, i_regwrite_m  input  ADDR_WIDTH/1  memory-stage destination and write enable.
REQ-010 i_rd_addr_w, i_regwrite_w  input  ADDR_WIDTH/1  writeback-stage destination and write enable.
REQ-011 i_halt_req  input  1  debug halt request, level.
REQ-012 i_resume  input  1  debug resume, single-cycle pulse.
REQ-013 o_stall_f, o_stall_d  output  1  hold PC and IF/ID register.
REQ-014 o_flush_d, o_flush_e  output  1  clear IF/ID and ID/EX registers.
REQ-015 o_fwd_a_e, o_fwd_b_e  output  2  ALU operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result.
REQ-016 o_halt_ack  output  1  pipeline drained and halted.
REQ-017 o_state  output  2  FSM state: 00 RUN, 01 DRAIN, 10 HALTED.

Function
REQ-018 Forwarding SHALL be combinational: select 10 if i_regwrite_m, i_rd_addr_m != 0 and i_rd_addr_m equals the EX source; else 01 under the same rule on the W inputs; else 00. M has priority over W.
REQ-019 Load-use hazard lwstall SHALL be i_resultsrc_e == 2'b01 and i_rd_addr_e != 0 and i_rd_addr_e matches i_rs1_addr_d or i_rs2_addr_d.
REQ-020 In RUN: o_stall_f = o_stall_d = lwstall and not i_pcsrc_e; o_flush_d = i_pcsrc_e; o_flush_e = lwstall or i_pcsrc_e.
REQ-021 RUN -> DRAIN SHALL occur on an edge where i_halt_req = 1, lwstall = 0 and i_pcsrc_e = 0; otherwise the request stays pending while the level is held.
REQ-022 On entry to DRAIN a 3-bit counter SHALL load DRAIN_CYCLES-1.
REQ-023 In DRAIN: o_stall_f = o_stall_d = 1, o_flush_e = 1, o_flush_d = 0. The counter decrements each cycle; DRAIN -> HALTED on the edge where the counter is 0.
REQ-024 In HALTED: o_stall_f = o_stall_d = o_flush_e = 1 and o_halt_ack = 1. HALTED -> RUN on i_resume = 1.
REQ-025 Halt latency SHALL be exactly DRAIN_CYCLES+1 edges from the accepting edge to o_halt_ack = 1.
REQ-026 i_resume SHALL be ignored outside HALTED. i_halt_req SHALL be ignored in DRAIN and HALTED, and deasserting it mid-DRAIN SHALL NOT abort the drain.
REQ-027 Simultaneous i_resume and i_halt_req in HALTED SHALL resume to RUN; a still-high i_halt_req is then re-evaluated in RUN on the next edge.
REQ-028 o_fwd_a_e and o_fwd_b_e SHALL follow REQ-018 in every state.
REQ-029 o_halt_ack SHALL be a registered output (state-decoded, glitch-free).

Reset
REQ-030 While i_rst_n = 0: state RUN, counter 0, o_halt_ack 0, o_state 00. Stall and flush outputs follow the RUN equations.
REQ-031 Reset asserted in DRAIN or HALTED SHALL return to RUN immediately, with o_halt_ack = 0 in the same cycle.

Verification
REQ-032 Forwarding: i_regwrite_m = 1, i_rd_addr_m = 5, i_regwrite_w = 1, i_rd_addr_w = 5, i_rs1_addr_e = 5 -> o_fwd_a_e = 10. With i_rd_addr_m = 0 instead -> 01. With i_rs1_addr_e = 0 -> 00.
REQ-033 Load-use: i_resultsrc_e = 01, i_rd_addr_e = 7, i_rs2_addr_d = 7 -> o_stall_f = o_stall_d = o_flush_e = 1, o_flush_d = 0. Adding i_pcsrc_e = 1 -> stalls 0, o_flush_d = o_flush_e = 1.
REQ-034 Halt: i_halt_req held high in RUN with no hazard -> o_state 01 for 3 cycles, then 10 with o_halt_ack = 1 on the 4th edge. i_resume pulse -> o_state 00 and o_halt_ack = 0 on the next edge.
REQ-035 Deferred halt: i_halt_req = 1 together with i_pcsrc_e = 1 for one cycle -> remains RUN that cycle, enters DRAIN on the following edge.
REQ-036 Reset mid-drain: assert i_rst_n = 0 with counter = 1 -> o_state 00 and o_halt_ack = 0 immediately. Ignored resume: i_resume pulse in DRAIN -> no state change.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall,
// branch flush and a debug halt FSM that drains the pipeline before acknowledging.
module pipeline_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr_d,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr_d,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr_e,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic [1:0]            i_resultsrc_e,
  input  logic                  i_pcsrc_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_m,
  input  logic                  i_regwrite_m,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_w,
  input  logic                  i_regwrite_w,
  input  logic                  i_halt_req,
  input  logic                  i_resume,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic [1:0]            o_fwd_a_e,
  output logic [1:0]            o_fwd_b_e,
  output logic                  o_halt_ack,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [2:0] drain_cnt;
  logic       halt_ack;
  logic       lwstall;

  // Memory-stage result is newer than writeback, so it wins on a double match.
  function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] rs);
    if (i_regwrite_m && (i_rd_addr_m != '0) && (i_rd_addr_m == rs))
      return 2'b10;
    else if (i_regwrite_w && (i_rd_addr_w != '0) && (i_rd_addr_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign o_fwd_a_e = fwd_sel(i_rs1_addr_e);
  assign o_fwd_b_e = fwd_sel(i_rs2_addr_e);

  assign lwstall = (i_resultsrc_e == 2'b01) && (i_rd_addr_e != '0) &&
                   ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    unique case (state)
      DRAIN, HALTED: begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_flush_e = 1'b1;
      end
      default: begin
        o_stall_f = lwstall && !i_pcsrc_e;
        o_stall_d = lwstall && !i_pcsrc_e;
        o_flush_d = i_pcsrc_e;
        o_flush_e = lwstall || i_pcsrc_e;
      end
    endcase
  end

  // Halt is only accepted on a hazard-free edge; a held request simply waits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      halt_ack  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (i_halt_req && !lwstall && !i_pcsrc_e) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= HALTED;
            halt_ack <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        HALTED: begin
          if (i_resume) begin
            state    <= RUN;
            halt_ack <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
          halt_ack  <= 1'b0;
        end
      endcase
    end
  end

  assign o_halt_ack = halt_ack;
  assign o_state    = state;

endmodule
